// File: rtl/wash_pkg.sv
// Shared definitions for the washer controller and its phase timer.
// Phase codes deliberately equal the washer FSM state codes so the FSM can
// drive its own state straight onto phase_sel.
package wash_pkg;

    localparam logic [1:0] PH_NONE  = 2'b00;
    localparam logic [1:0] PH_WASH  = 2'b01;
    localparam logic [1:0] PH_RINSE = 2'b10;
    localparam logic [1:0] PH_DRY   = 2'b11;

    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_RUN   = 2'b01,
        T_PAUSE = 2'b10,
        T_DONE  = 2'b11
    } timer_state_t;

endpackage

// File: rtl/cycle_phase_timer_if.sv
// Control link between the washer FSM (master) and the phase timer (slave).
// Signalling: no valid/ready pair is used. start, enable and phase_sel are
// levels sampled on every rising clk edge; start acts once per sampled edge,
// so the master pulses it for one cycle per reload. timer_done is a
// one-cycle pulse with no back-pressure; the master must act on it in that
// cycle. counter_out, busy and phase_active are registered status levels.
interface cycle_phase_timer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             enable;
    logic [1:0]       phase_sel;
    logic             timer_done;
    logic [CNT_W-1:0] counter_out;
    logic             busy;
    logic [1:0]       phase_active;

    modport master (
        output start, enable, phase_sel,
        input  timer_done, counter_out, busy, phase_active
    );

    modport slave (
        input  start, enable, phase_sel,
        output timer_done, counter_out, busy, phase_active
    );
endinterface

// File: rtl/cycle_phase_timer_tick_prescaler.sv
// Divides enabled clock cycles down to one count tick every PRESCALE cycles.
// tick is combinational so the parent decrements on the same edge the
// prescale count wraps.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count_q;

    assign tick_o = en_i && (count_q == LAST);

    // Prescale count: clear has priority, frozen while not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            if (count_q == LAST) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + PW'(1);
            end
        end
    end
endmodule

// File: rtl/cycle_phase_timer.sv
// Per-phase countdown timer for the washer FSM. Loads the selected phase's
// duration on start or on a phase change, counts down once per PRESCALE
// enabled cycles, and emits one timer_done pulse when the count expires.
module cycle_phase_timer
    import wash_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int PRESCALE    = 4,
    parameter int WASH_TICKS  = 10,
    parameter int RINSE_TICKS = 6,
    parameter int DRY_TICKS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cycle_phase_timer_if.slave   tmr,
    output timer_state_t         state_o
);
    timer_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       phase_q;
    logic             done_q;
    logic             busy_q;

    logic [CNT_W-1:0] dur_d;
    logic             trigger;
    logic             count_en;
    logic             tick;

    // Duration lookup for the phase being requested.
    always_comb begin
        dur_d = '0;
        case (tmr.phase_sel)
            PH_WASH:  dur_d = CNT_W'(WASH_TICKS);
            PH_RINSE: dur_d = CNT_W'(RINSE_TICKS);
            PH_DRY:   dur_d = CNT_W'(DRY_TICKS);
            default:  dur_d = '0;
        endcase
    end

    // A reload outranks everything else, including an expiry on the same edge.
    assign trigger  = tmr.start || (tmr.enable && (tmr.phase_sel != phase_q));
    assign count_en = tmr.enable && !trigger &&
                      ((state_q == T_RUN) || (state_q == T_PAUSE));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (trigger),
        .en_i    (count_en),
        .tick_o  (tick)
    );

    // Timer FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            phase_q <= PH_NONE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (trigger) begin
            done_q <= 1'b0;
            if (tmr.phase_sel != PH_NONE) begin
                phase_q <= tmr.phase_sel;
                cnt_q   <= dur_d;
                state_q <= tmr.enable ? T_RUN : T_PAUSE;
                busy_q  <= 1'b1;
            end else begin
                phase_q <= PH_NONE;
                cnt_q   <= '0;
                state_q <= T_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                T_RUN, T_PAUSE: begin
                    if (tmr.enable) begin
                        state_q <= T_RUN;
                        if (tick && (cnt_q != '0)) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                state_q <= T_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end else begin
                        state_q <= T_PAUSE;
                    end
                end
                default: begin
                    // IDLE and DONE wait for a reload.
                end
            endcase
        end
    end

    assign tmr.timer_done   = done_q;
    assign tmr.counter_out  = cnt_q;
    assign tmr.busy         = busy_q;
    assign tmr.phase_active = phase_q;
    assign state_o          = state_q;
endmodule

// File: doc/cycle_phase_timer.md
Name: cycle_phase_timer

Overview:
- Per-phase countdown timer serving the washer control FSM.
- The FSM drives enable and phase_sel. This block answers with a single-cycle timer_done pulse when the selected phase's programmed duration has elapsed.
- Sits directly below the washer FSM and is its only time base.
- Provides prescaled counting, pause/resume on enable, and restart on start or a phase change.

Parameters:
- CNT_W, 16: width of the remaining-count register and counter_out.
- PRESCALE, 4: clock cycles per count decrement; legal range ≥1; PRESCALE=1 means decrement every enabled cycle.
- WASH_TICKS, 10: wash duration in counts; legal range 1..2^CNT_W-1.
- RINSE_TICKS, 6: rinse duration in counts; same range.
- DRY_TICKS, 8: dry duration in counts; same range.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst_n, input, 1: reset. Asynchronous, active-low.
- start, input, 1: reload request; level sampled each edge.
- enable, input, 1: count enable; low freezes all counting.
- phase_sel, input, 2: 00 none, 01 wash, 10 rinse, 11 dry.
- timer_done, output, 1: one-cycle registered pulse at phase expiry.
- counter_out, output, CNT_W: remaining counts of the active phase.
- busy, output, 1: high in RUN or PAUSE.
- phase_active, output, 2: phase latched at the last load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter_out=0, prescale count=0.
  - timer_done=0, busy=0, phase_active=00.
- States:
  - IDLE: no phase loaded.
  - RUN: counting.
  - PAUSE: loaded but frozen.
  - DONE: expired, counter_out=0.
- Reload trigger, evaluated every edge, any state: (start=1) OR (enable=1 AND phase_sel≠phase_active).
- Load action:
  - Performed on an edge where the trigger is true and phase_sel≠00.
  - Sets phase_active=phase_sel, counter_out=duration(phase_sel), prescale count=0.
  - Next state is RUN if enable=1, else PAUSE.
  - timer_done=0 that cycle.
- Trigger with phase_sel=00:
  - Goes to IDLE, counter_out=0, phase_active=00, busy=0, no pulse.
- RUN with enable=1:
  - Prescale count increments each cycle.
  - When it equals PRESCALE-1, it wraps to 0 and counter_out decrements by 1.
- RUN with enable=0: state goes to PAUSE; counter_out and prescale count hold.
- PAUSE with enable=1 and no trigger: return to RUN and resume from the held values; no reload.
- Expiry:
  - The edge at which counter_out goes 1→0 also sets timer_done=1 and moves to DONE.
  - timer_done clears on the next edge.
  - Latency from load edge to timer_done high = duration×PRESCALE cycles.
- DONE:
  - Holds counter_out=0, busy=0; timer_done=0 after the pulse cycle.
  - Leaves only on a reload trigger or reset.
  - Exactly one pulse per load.
- Simultaneous events:
  - Reload trigger on the same edge as expiry: reload wins; timer_done suppressed.
  - start=1 held high: reloads every edge, so the timer never expires. The controlling FSM must pulse start.
- Phase change mid-RUN or mid-PAUSE: restart with the new phase duration; no done pulse for the aborted phase.
- Arithmetic:
  - counter_out never wraps below 0.
  - Prescale counter width is clog2(PRESCALE), minimum 1 bit.
- Reset mid-operation: immediate return to reset values; no pulse generated.

Decomposition:
- Shared package wash_pkg:
  - Phase codes PH_NONE=2'b00, PH_WASH=2'b01, PH_RINSE=2'b10, PH_DRY=2'b11. These match the washer FSM state codes.
  - Timer state encoding T_IDLE, T_RUN, T_PAUSE, T_DONE.
- One sub-module, tick_prescaler:
  - Inputs: clk, rst_n, clear, en. Output: tick.
  - tick is combinational high when count==PRESCALE-1 and en=1.
  - Parent pulses clear on load.

Test Plan:
1. Defaults, PRESCALE=2, WASH_TICKS=3: enable=1, phase_sel=01 from reset → load at edge 1 with counter_out=3; timer_done high for exactly 1 cycle, 6 cycles after the load edge; counter_out=0, busy=0.
2. Pause/resume: wash running, drop enable for 5 cycles after counter_out=2 → counter_out holds 2, busy stays 1; done arrives 5 cycles later than in case 1; no reload.
3. Phase change mid-run: rinse loaded (6), switch phase_sel to 11 when counter_out=4 → reload to 8, phase_active=11; no pulse for rinse; single pulse 8×PRESCALE cycles later.
4. Collision: assert start on the exact expiry edge → timer_done stays 0, counter_out reloaded, state RUN.
5. Async reset: assert rst_n=0 mid-count between clock edges → outputs go to 0 without waiting for clk; after release with phase_sel=00, timer stays IDLE and never pulses.
6. Full washer sequence with the FSM: three timer_done pulses in wash→rinse→dry order, spaced (10, 6, 8)×4 cycles plus reload cycles.
